tick_handshake: RTL

TICK_HANDSHAKE -- requirements
Module: tick_handshake

---
 rtl/tick_handshake.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tick_handshake.sv
// Tick-counting request generator: raises req after M ticks, waits up to T ticks
// for ack, and latches a sticky err on timeout. FSM state is visible on state_dbg.
module tick_handshake #(
  parameter int M     = 8,
  parameter int T     = 4,
  parameter int SBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ack,
  output logic             req,
  output logic             busy,
  output logic             err,
  output logic [SBITS-1:0] served,
  output logic             ok,
  output logic [1:0]       state_dbg
);

  // Handshake: req is a level held from the edge after the M-th tick until the
  // edge on which ack is sampled high; ack outside WAIT is ignored, and an ack
  // coincident with the timeout tick is treated as a successful handshake.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam logic [15:0]      M_LAST = 16'(M - 1);
  localparam logic [15:0]      M_LIM  = 16'(M);
  localparam logic [7:0]       T_LAST = 8'(T - 1);
  localparam logic [7:0]       T_LIM  = 8'(T);
  localparam logic [SBITS-1:0] S_ONE  = SBITS'(1);

  state_t           state, state_nxt;
  logic [15:0]      tcnt, tcnt_nxt;
  logic [7:0]       wcnt, wcnt_nxt;
  logic             req_nxt, busy_nxt, err_nxt, ok_nxt;
  logic [SBITS-1:0] served_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      wcnt   <= '0;
      req    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      served <= '0;
      ok     <= 1'b1;
    end else begin
      state  <= state_nxt;
      tcnt   <= tcnt_nxt;
      wcnt   <= wcnt_nxt;
      req    <= req_nxt;
      busy   <= busy_nxt;
      err    <= err_nxt;
      served <= served_nxt;
      ok     <= ok_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tcnt_nxt   = tcnt;
    wcnt_nxt   = wcnt;
    req_nxt    = req;
    busy_nxt   = busy;
    err_nxt    = err;
    served_nxt = served;
    case (state)
      IDLE: begin
        if (tick) begin
          if (tcnt == M_LAST) begin
            tcnt_nxt  = '0;
            state_nxt = WAIT;
            req_nxt   = 1'b1;
            busy_nxt  = 1'b1;
          end else begin
            tcnt_nxt = tcnt + 16'd1;
          end
        end
      end
      WAIT: begin
        tcnt_nxt = '0;
        if (ack) begin
          state_nxt  = IDLE;
          req_nxt    = 1'b0;
          busy_nxt   = 1'b0;
          wcnt_nxt   = '0;
          served_nxt = served + S_ONE;
        end else if (tick) begin
          if (wcnt == T_LAST) begin
            // wcnt is cleared on entry to FAIL so the invariant still holds there.
            state_nxt = FAIL;
            req_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            err_nxt   = 1'b1;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
      end
      FAIL: begin
        req_nxt  = 1'b0;
        busy_nxt = 1'b0;
        err_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        tcnt_nxt  = '0;
        wcnt_nxt  = '0;
        req_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
    ok_nxt = (tcnt_nxt < M_LIM) && (wcnt_nxt < T_LIM);
  end

  assign state_dbg = state;

endmodule
